lif_scheduler: RTL and testbench

LIF_SCHEDULER -- requirements
Module: lif_scheduler

---
 rtl/lif_scheduler.sv | 159 +++++++++++++++
 tb/tb_lif_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lif_scheduler.sv
// rtl/lif_scheduler.sv - time-multiplexed leaky integrate-and-fire neuron scheduler
module lif_scheduler #(
   parameter int N         = 4,
   parameter int V_SIZE    = 3,
   parameter int THRESHOLD = 8,
   parameter int LEAK      = 1,
   parameter int W         = 3,
   localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              clear,
   input  logic [N-1:0]      in_spikes,
   output logic              busy,
   output logic              done,
   output logic [N-1:0]      spike_out,
   input  logic [IW-1:0]     rd_idx,
   output logic [V_SIZE:0]   rd_volt
);

   localparam int EW    = V_SIZE + 2;
   localparam int DEPTH = 1 << IW;

   localparam logic [EW-1:0]     W_L    = EW'(W);
   localparam logic [EW-1:0]     LEAK_L = EW'(LEAK);
   localparam logic [EW-1:0]     THR_L  = EW'(THRESHOLD);
   localparam logic [V_SIZE:0]   VMAX   = '1;
   localparam logic [EW-1:0]     VMAX_E = {1'b0, VMAX};
   localparam logic [IW-1:0]     LAST   = IW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UPDATE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Depth is rounded up to a power of two so rd_idx never reads outside the
   // array; entries at N and above are never written and stay zero.
   logic [V_SIZE:0] volt [DEPTH];
   logic [N-1:0]    in_lat;
   logic [N-1:0]    spike_acc;
   logic [IW-1:0]   idx;

   logic [EW-1:0]   in_val;
   logic [EW-1:0]   sum;
   logic [EW-1:0]   diff;
   logic [V_SIZE:0] result;
   logic            fire;
   logic [V_SIZE:0] volt_new;
   logic [N-1:0]    spike_nxt;
   logic            last;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (!clear && start) begin
               state_nxt = S_UPDATE;
            end
         end
         S_UPDATE: begin
            if (last) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM outputs ----------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_UPDATE: busy = 1'b1;
         S_DONE:   done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // ---------------- LIF update datapath ----------------
   assign last = (idx == LAST);

   always_comb begin
      in_val = in_lat[idx] ? W_L : '0;
      sum    = {1'b0, volt[idx]} + in_val;
      diff   = sum - LEAK_L;
      result = '0;
      // A weight with its top bit set would overflow the sum; treat as saturation.
      if (in_val[EW-1]) begin
         result = VMAX;
      end else if (sum > LEAK_L) begin
         result = (diff > VMAX_E) ? VMAX : diff[V_SIZE:0];
      end
      fire     = ({1'b0, result} >= THR_L);
      volt_new = fire ? '0 : result;
   end

   always_comb begin
      spike_nxt      = spike_acc;
      spike_nxt[idx] = fire;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            volt[i] <= '0;
         end
         in_lat    <= '0;
         spike_acc <= '0;
         spike_out <= '0;
         idx       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (clear) begin
                  for (int i = 0; i < DEPTH; i++) begin
                     volt[i] <= '0;
                  end
               end else if (start) begin
                  in_lat    <= in_spikes;
                  idx       <= '0;
                  spike_acc <= '0;
               end
            end
            S_UPDATE: begin
               volt[idx] <= volt_new;
               spike_acc <= spike_nxt;
               idx       <= idx + 1'b1;
               if (last) begin
                  spike_out <= spike_nxt;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign rd_volt = volt[rd_idx];

endmodule

// File: tb/tb_lif_scheduler.sv
// tb/tb_lif_scheduler.sv - directed self-checking bench for lif_scheduler
module tb_lif_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       clear;
   logic [3:0] in_spikes;
   logic [1:0] rd_idx;

   logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;
   logic [3:0] spk_a, spk_b, spk_c;
   logic [3:0] volt_a, volt_b, volt_c;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   lif_scheduler u_a (
      .clk(clk), .reset(reset), .start(start), .clear(clear), .in_spikes(in_spikes),
      .busy(busy_a), .done(done_a), .spike_out(spk_a), .rd_idx(rd_idx), .rd_volt(volt_a)
   );

   lif_scheduler #(.W(14)) u_b (
      .clk(clk), .reset(reset), .start(start), .clear(clear), .in_spikes(in_spikes),
      .busy(busy_b), .done(done_b), .spike_out(spk_b), .rd_idx(rd_idx), .rd_volt(volt_b)
   );

   lif_scheduler #(.W(14), .THRESHOLD(16)) u_c (
      .clk(clk), .reset(reset), .start(start), .clear(clear), .in_spikes(in_spikes),
      .busy(busy_c), .done(done_c), .spike_out(spk_c), .rd_idx(rd_idx), .rd_volt(volt_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_v(input string tag, input int idx, input logic [3:0] ea,
                        input logic [3:0] ec);
      rd_idx = 2'(idx);
      #1;
      chk({tag, "_va"}, {28'd0, volt_a}, {28'd0, ea});
      chk({tag, "_vc"}, {28'd0, volt_c}, {28'd0, ec});
   endtask

   task automatic run_ts(input logic [3:0] spikes);
      int c;
      @(negedge clk);
      in_spikes = spikes;
      start     = 1'b1;
      @(posedge clk);
      #1 start  = 1'b0;
      c = 0;
      while (!done_a && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("done_seen", {31'd0, done_a}, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      clear     = 1'b0;
      in_spikes = '0;
      rd_idx    = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy_a}, 32'd0);
      chk("rst_done", {31'd0, done_a}, 32'd0);
      chk("rst_spk",  {28'd0, spk_a},  32'd0);
      chk_v("rst_v0", 0, 4'd0, 4'd0);
      reset = 1'b1;

      // steady drive on neuron 0
      run_ts(4'b0001);
      chk_v("s1", 0, 4'd2, 4'd13);
      chk("s1_spka", {28'd0, spk_a}, 32'h0);
      chk("s1_spkb", {28'd0, spk_b}, 32'h1);
      chk_v("s1b", 0, 4'd2, 4'd13);
      chk("s1_vb0", {28'd0, volt_b}, 32'd0);
      run_ts(4'b0001);
      chk_v("s2", 0, 4'd4, 4'd15);
      chk("s2_spka", {28'd0, spk_a}, 32'h0);
      run_ts(4'b0001);
      chk_v("s3", 0, 4'd6, 4'd15);
      chk("s3_spka", {28'd0, spk_a}, 32'h0);
      run_ts(4'b0001);
      chk_v("s4", 0, 4'd0, 4'd15);
      chk("s4_spka", {28'd0, spk_a}, 32'h1);
      chk("s4_spkc", {28'd0, spk_c}, 32'h0);
      for (int i = 1; i < 4; i++) chk_v("s4_other", i, 4'd0, 4'd0);

      // leak to floor on neuron 1
      run_ts(4'b0010);
      chk_v("l0", 1, 4'd2, 4'd13);
      chk("l0_spka", {28'd0, spk_a}, 32'h0);
      chk("l0_spkb", {28'd0, spk_b}, 32'h2);
      run_ts(4'b0000);
      chk_v("l1", 1, 4'd1, 4'd12);
      run_ts(4'b0000);
      chk_v("l2", 1, 4'd0, 4'd11);
      run_ts(4'b0000);
      chk_v("l3", 1, 4'd0, 4'd10);
      chk_v("l3_n0", 0, 4'd0, 4'd11);
      chk("l3_spka", {28'd0, spk_a}, 32'h0);

      // handshake timing with stray start/clear during busy
      @(negedge clk);
      in_spikes = 4'b0100;
      start     = 1'b1;
      @(posedge clk);
      #1 start  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("hs_busy", {31'd0, busy_a}, 32'd1);
         chk("hs_done", {31'd0, done_a}, 32'd0);
         if (i == 1) begin
            start     = 1'b1;
            clear     = 1'b1;
            in_spikes = 4'b1111;
         end
         if (i == 2) begin
            start = 1'b0;
            clear = 1'b0;
         end
      end
      @(negedge clk);
      chk("hs_dn_busy", {31'd0, busy_a}, 32'd0);
      chk("hs_dn_done", {31'd0, done_a}, 32'd1);
      @(negedge clk);
      chk("hs_idle_done", {31'd0, done_a}, 32'd0);
      chk("hs_idle_busy", {31'd0, busy_a}, 32'd0);
      @(negedge clk);
      chk("hs_noextra", {31'd0, busy_a}, 32'd0);
      in_spikes = 4'b0000;
      chk_v("hs_n2", 2, 4'd2, 4'd13);
      chk_v("hs_n0", 0, 4'd0, 4'd10);
      chk_v("hs_n3", 3, 4'd0, 4'd0);
      chk("hs_spkb", {28'd0, spk_b}, 32'h4);

      // start and clear together in IDLE
      @(negedge clk);
      start = 1'b1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("clr_busy", {31'd0, busy_a}, 32'd0);
         chk("clr_done", {31'd0, done_a}, 32'd0);
      end
      for (int i = 0; i < 4; i++) chk_v("clr_v", i, 4'd0, 4'd0);
      chk("clr_spkb", {28'd0, spk_b}, 32'h4);
      chk("clr_spka", {28'd0, spk_a}, 32'h0);

      // reset in the middle of an update
      run_ts(4'b1111);
      chk_v("pre_n3", 3, 4'd2, 4'd13);
      chk("pre_spkb", {28'd0, spk_b}, 32'hf);
      @(negedge clk);
      in_spikes = 4'b1111;
      start     = 1'b1;
      @(posedge clk);
      #1 start  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset  = 1'b0;
      #1;
      chk("mr_busy", {31'd0, busy_a}, 32'd0);
      chk("mr_done", {31'd0, done_a}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mr_nodone", {31'd0, done_a}, 32'd0);
      end
      for (int i = 0; i < 4; i++) chk_v("mr_v", i, 4'd0, 4'd0);
      chk("mr_spka", {28'd0, spk_a}, 32'h0);
      chk("mr_spkb", {28'd0, spk_b}, 32'h0);
      reset = 1'b1;
      run_ts(4'b0001);
      chk_v("ar_n0", 0, 4'd2, 4'd13);
      chk_v("ar_n1", 1, 4'd0, 4'd0);
      chk_v("ar_n3", 3, 4'd0, 4'd0);
      chk("ar_spkb", {28'd0, spk_b}, 32'h1);
      chk("ar_spka", {28'd0, spk_a}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
